vga_timing_gen: RTL and testbench

- Generates raster timing for the start/level screen overlay and the other pixel-domain renderers.
- Drives hcount/vcount, de, hsync and vsync.
- The vsync output is the per-frame signal the overlay stages use to clear their ROM address counters. It stays high for the whole frame and drops low only during the sync pulse.
- Sits directly upstream of the overlay/renderer stages and the VGA pins; one instance per display.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_axis_cnt.sv | 51 +++++
 rtl/vga_timing_gen.sv | 95 +++++++++
 tb/tb_vga_timing_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the pixel-domain blocks.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

    localparam int COORD_W   = 12;
    localparam int MAX_TOTAL = 1 << COORD_W;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter plus active/sync window flags.
// The flags are registered from the next count so they line up with count.
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic               pixelclk,
    input  logic               reset_n,
    input  logic               advance,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               in_active,
    output logic               in_sync
);

    localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = SYNC_START + SYNC;

    coord_t      count_next;
    logic [31:0] next_wide;

    assign wrap      = (count == COORD_W'(TOTAL - 1));
    assign next_wide = 32'(count_next);

    // NOTE: default assignment first so the hold case cannot infer a latch.
    always_comb begin
        count_next = count;
        if (advance) begin
            count_next = wrap ? '0 : count + COORD_W'(1);
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= COORD_W'(TOTAL - 1);
            in_active <= 1'b0;
            in_sync   <= 1'b0;
        end else begin
            count     <= count_next;
            in_active <= (next_wide < 32'(ACTIVE));
            in_sync   <= (next_wide >= 32'(SYNC_START)) && (next_wide < 32'(SYNC_END));
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: counters, display enable, syncs and start pulses.
// Every output is a flop (or a flop combined with a constant/other flop).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic               pixelclk,
    input  logic               reset_n,
    input  logic               en,
    output logic [COORD_W-1:0] hcount,
    output logic [COORD_W-1:0] vcount,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
        $error("vga_timing_gen: raster totals exceed the coordinate width");
    end

    logic   h_wrap, h_in_active, h_in_sync;
    logic   v_wrap, v_in_active, v_in_sync;
    logic   v_advance;
    coord_t v_next;

    // The line counter steps in the same edge the pixel counter wraps.
    assign v_advance = en & h_wrap;

    vga_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_cnt (
        .pixelclk  (pixelclk),
        .reset_n   (reset_n),
        .advance   (en),
        .count     (hcount),
        .wrap      (h_wrap),
        .in_active (h_in_active),
        .in_sync   (h_in_sync)
    );

    vga_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_cnt (
        .pixelclk  (pixelclk),
        .reset_n   (reset_n),
        .advance   (v_advance),
        .count     (vcount),
        .wrap      (v_wrap),
        .in_active (v_in_active),
        .in_sync   (v_in_sync)
    );

    always_comb begin
        v_next = vcount;
        if (v_advance) begin
            v_next = v_wrap ? '0 : vcount + COORD_W'(1);
        end
    end

    // Pulses fire only on an enabled edge that lands on hcount==0.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= v_advance && (32'(v_next) < 32'(V_ACTIVE));
            frame_start <= v_advance && (v_next == '0);
        end
    end

    assign de    = h_in_active & v_in_active;
    assign hsync = h_in_sync ? SYNC_POL : ~SYNC_POL;
    assign vsync = v_in_sync ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two generator instances (default and a small raster with
// active-high syncs) compared every cycle against a linear-pixel-index model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [11:0] h;
        logic [11:0] v;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct {
        int ha, hf, hsw, hb;
        int va, vf, vsw, vb;
        bit pol;
    } cfg_t;

    cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    cfg_t cfg_b = '{16, 2, 3, 3, 8, 2, 2, 3, 1'b1};

    logic pixelclk = 1'b0;
    logic reset_n  = 1'b0;
    logic en       = 1'b0;

    logic [11:0] hcount_a, vcount_a, hcount_b, vcount_b;
    logic        de_a, hsync_a, vsync_a, ls_a, fs_a;
    logic        de_b, hsync_b, vsync_b, ls_b, fs_b;
    obs_t        obs_a, obs_b, exp_a, exp_b;

    obs_t q_a[$];
    obs_t q_b[$];
    int   fs_times_b[$];
    int   cyc        = 0;
    int   hs_low_cnt = 0;
    int   pos_a, pos_b;
    int   passed     = 0;
    int   total      = 0;

    always #5 pixelclk = ~pixelclk;

    vga_timing_gen dut_a (
        .pixelclk    (pixelclk),
        .reset_n     (reset_n),
        .en          (en),
        .hcount      (hcount_a),
        .vcount      (vcount_a),
        .de          (de_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .line_start  (ls_a),
        .frame_start (fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (1'b1)
    ) dut_b (
        .pixelclk    (pixelclk),
        .reset_n     (reset_n),
        .en          (en),
        .hcount      (hcount_b),
        .vcount      (vcount_b),
        .de          (de_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .line_start  (ls_b),
        .frame_start (fs_b)
    );

    assign obs_a = {hcount_a, vcount_a, de_a, hsync_a, vsync_a, ls_a, fs_a};
    assign obs_b = {hcount_b, vcount_b, de_b, hsync_b, vsync_b, ls_b, fs_b};

    function automatic int h_total(cfg_t c);
        return c.ha + c.hf + c.hsw + c.hb;
    endfunction

    function automatic int frame_len(cfg_t c);
        return h_total(c) * (c.va + c.vf + c.vsw + c.vb);
    endfunction

    // Expected outputs for raster position pos (pixels since frame start).
    function automatic obs_t model_out(cfg_t c, int pos, bit pulses, bit in_reset);
        obs_t o;
        int   h = pos % h_total(c);
        int   v = pos / h_total(c);
        o.h = 12'(h);
        o.v = 12'(v);
        if (in_reset) begin
            o.de = 1'b0;
            o.hs = !c.pol;
            o.vs = !c.pol;
            o.ls = 1'b0;
            o.fs = 1'b0;
        end else begin
            o.de = (h < c.ha) && (v < c.va);
            o.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) ? c.pol : !c.pol;
            o.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) ? c.pol : !c.pol;
            o.ls = pulses && (h == 0) && (v < c.va);
            o.fs = pulses && (pos == 0);
        end
        return o;
    endfunction

    task automatic check_obs(string name, obs_t got, obs_t want);
        total++;
        if (got === want) begin
            passed++;
        end else begin
            $display("FAIL %s t=%0t: got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b, expected h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                     name, $time, got.h, got.v, got.de, got.hs, got.vs, got.ls, got.fs,
                     want.h, want.v, want.de, want.hs, want.vs, want.ls, want.fs);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    // Monitor: pops one expectation per clock and compares after the edge.
    always @(posedge pixelclk) begin
        cyc++;
        #1;
        if (vcount_a == 12'd0 && hsync_a == 1'b0) hs_low_cnt++;
        if (fs_b === 1'b1) fs_times_b.push_back(cyc);
        if (q_a.size() > 0) begin
            exp_a = q_a.pop_front();
            check_obs("dut_a", obs_a, exp_a);
        end
        if (q_b.size() > 0) begin
            exp_b = q_b.pop_front();
            check_obs("dut_b", obs_b, exp_b);
        end
    end

    // Drive one cycle of stimulus and queue what the following edge must show.
    task automatic step(bit e, bit r);
        @(negedge pixelclk);
        en      = e;
        reset_n = r;
        if (!r) begin
            pos_a = frame_len(cfg_a) - 1;
            pos_b = frame_len(cfg_b) - 1;
            q_a.push_back(model_out(cfg_a, pos_a, 1'b0, 1'b1));
            q_b.push_back(model_out(cfg_b, pos_b, 1'b0, 1'b1));
        end else begin
            if (e) begin
                pos_a = (pos_a + 1) % frame_len(cfg_a);
                pos_b = (pos_b + 1) % frame_len(cfg_b);
            end
            q_a.push_back(model_out(cfg_a, pos_a, e, 1'b0));
            q_b.push_back(model_out(cfg_b, pos_b, e, 1'b0));
        end
    endtask

    // Reset asserted between edges must take effect without a clock.
    task automatic async_reset_pulse();
        @(posedge pixelclk);
        #3;
        reset_n = 1'b0;
        #1;
        pos_a = frame_len(cfg_a) - 1;
        pos_b = frame_len(cfg_b) - 1;
        check_obs("async_reset_a", obs_a, model_out(cfg_a, pos_a, 1'b0, 1'b1));
        check_obs("async_reset_b", obs_b, model_out(cfg_b, pos_b, 1'b0, 1'b1));
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
    endtask

    initial begin
        pos_a = frame_len(cfg_a) - 1;
        pos_b = frame_len(cfg_b) - 1;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

        // First line of the default raster, counting the hsync pulse width.
        for (int i = 0; i < 800; i++) step(1'b1, 1'b1);
        check_int("hsync_low_cycles_line0", hs_low_cnt, 96);

        for (int i = 0; i < 5000 && pos_a != 5 * 800 + 300; i++) step(1'b1, 1'b1);
        check_int("reached_h300_v5", pos_a, 5 * 800 + 300);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0, 1'b1);

        for (int i = 0; i < 1000 && (pos_a % 800) != 400; i++) step(1'b1, 1'b1);
        check_int("reached_h400", pos_a % 800, 400);
        async_reset_pulse();

        fs_times_b.delete();
        for (int i = 0; i < 3 * 360 + 5; i++) step(1'b1, 1'b1);
        check_int("fs_b_pulse_count_ok", int'(fs_times_b.size() >= 3), 1);
        if (fs_times_b.size() >= 3) begin
            check_int("fs_b_period_0", fs_times_b[1] - fs_times_b[0], 360);
            check_int("fs_b_period_1", fs_times_b[2] - fs_times_b[1], 360);
        end

        for (int i = 0; i < 1500; i++) step($urandom_range(0, 4) != 0, 1'b1);

        @(posedge pixelclk);
        #3;
        check_int("scoreboard_drained", q_a.size() + q_b.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
